// File: rtl/zap_tb_mem_pkg.sv
// zap_tb_mem_pkg
// Shared definitions for the ZAP bench memory controller: the user-mode
// encoding, the data-port state encoding, the LFSR tap mask and the abort
// check used by both the code and data ports.
package zap_tb_mem_pkg;

  localparam logic [4:0] USR_MODE = 5'b10000;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_WAIT = 2'd1,
    D_DONE = 2'd2
  } dstate_t;

  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // An access aborts when it falls outside the array, or when it is a
  // user-mode access inside [base, limit). base == limit gives an empty window.
  function automatic logic abort_check(input logic [31:0] addr,
                                       input logic [31:0] cpsr,
                                       input logic [31:0] size,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
    logic out_of_range;
    logic in_window;
    out_of_range = (addr >= size);
    in_window    = (cpsr[4:0] == USR_MODE) && (addr >= base) && (addr < limit);
    return out_of_range || in_window;
  endfunction

endpackage

// File: rtl/zap_tb_lfsr16.sv
// zap_tb_lfsr16
// 16-bit Fibonacci LFSR used to generate pseudo-random data-port stalls.
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset, reloads SEED
//   i_en     advance one step per cycle when high
//   o_lfsr   current register value
module zap_tb_lfsr16
  import zap_tb_mem_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  output logic [15:0] o_lfsr
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_lfsr <= SEED;
    end else if (i_en) begin
      o_lfsr <= {o_lfsr[14:0], ^(o_lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/zap_tb_mem_ctrl.sv
// zap_tb_mem_ctrl
// Dual-port (code + data) behavioural memory for ZAP core benches with
// programmable wait states, optional random data stalls and a user-mode
// protected window that raises aborts.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_iaddress              fetch address
//   o_idata, o_code_hit     fetched word and its valid flag
//   o_code_abort            fetch abort, only meaningful with o_code_hit
//   i_daddress              data address
//   i_rd_en, i_wr_en        load / store request (both high = store)
//   i_ben, i_ddata          store byte enables and store data
//   o_ddata                 load data (pre-write word on a store)
//   o_data_stall            data access still in progress
//   o_data_abort            data abort, completion cycle only
//   i_cpsr                  processor status; mode field selects user mode
//
// Data port states:
//   state  | meaning
//   D_IDLE | no access in flight; first stall cycle of a new request
//   D_WAIT | counting down remaining wait cycles (dcnt)
//   D_DONE | completion cycle: data/abort valid, store commits at its end
module zap_tb_mem_ctrl
  import zap_tb_mem_pkg::*;
#(
  parameter int unsigned SIZE_IN_BYTES = 4096,
  parameter int unsigned CODE_WAIT     = 1,
  parameter int unsigned DATA_WAIT     = 2,
  parameter bit          RAND_STALL_EN = 1'b0,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic [31:0] PROT_BASE     = 32'h0000_0000,
  parameter logic [31:0] PROT_LIMIT    = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_iaddress,
  output logic [31:0] o_idata,
  output logic        o_code_hit,
  output logic        o_code_abort,
  input  logic [31:0] i_daddress,
  input  logic        i_rd_en,
  input  logic        i_wr_en,
  input  logic [3:0]  i_ben,
  input  logic [31:0] i_ddata,
  output logic [31:0] o_ddata,
  output logic        o_data_stall,
  output logic        o_data_abort,
  input  logic [31:0] i_cpsr
);

  localparam int unsigned DEPTH  = SIZE_IN_BYTES / 4;
  localparam int          IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SIZE_W = 32'(SIZE_IN_BYTES);
  localparam logic [3:0]  CW4    = 4'(CODE_WAIT);
  localparam logic [4:0]  DW5    = 5'(DATA_WAIT);

  // Not reset: contents survive reset and are preloaded/dumped by name.
  logic [31:0] mem [0:DEPTH-1];

  // ---------------------------------------------------------------------
  // Random stall source
  // ---------------------------------------------------------------------
  logic [15:0] lfsr;
  logic        lfsr_unused;

  zap_tb_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (1'b1),
    .o_lfsr  (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:2];

  // ---------------------------------------------------------------------
  // Data port
  // ---------------------------------------------------------------------
  dstate_t     state_q, state_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic        d_req;
  logic        d_in_range;
  logic [IW-1:0] d_idx;
  logic [31:0] d_word;
  logic        d_abort;
  logic        d_complete;
  logic [4:0]  w_total;
  logic [4:0]  w_m1;
  logic [3:0]  dcnt_load;

  assign d_req      = i_rd_en | i_wr_en;
  assign d_in_range = (i_daddress < SIZE_W);
  assign d_idx      = i_daddress[IW+1:2];
  assign d_word     = d_in_range ? mem[d_idx] : 32'd0;
  assign d_abort    = abort_check(i_daddress, i_cpsr, SIZE_W, PROT_BASE, PROT_LIMIT);

  // W stall cycles = one in D_IDLE plus dcnt_load in D_WAIT. dcnt_load
  // saturates so the 4-bit counter cannot wrap at the top of the range.
  assign w_total   = DW5 + (RAND_STALL_EN ? {3'b000, lfsr[1:0]} : 5'd0);
  assign w_m1      = w_total - 5'd1;
  assign dcnt_load = (w_m1 > 5'd15) ? 4'hF : w_m1[3:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= D_IDLE;
      dcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      D_IDLE: begin
        if (d_req) begin
          if (w_total == 5'd0) begin
            state_d = D_DONE;
          end else begin
            dcnt_d  = dcnt_load;
            state_d = (dcnt_load == 4'd0) ? D_DONE : D_WAIT;
          end
        end
      end
      D_WAIT: begin
        if (!d_req) begin
          state_d = D_IDLE;
          dcnt_d  = 4'd0;
        end else begin
          dcnt_d = dcnt_q - 4'd1;
          if (dcnt_q <= 4'd1) begin
            state_d = D_DONE;
          end
        end
      end
      D_DONE:  state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  always_comb begin
    o_data_stall = 1'b0;
    d_complete   = 1'b0;
    if (!i_reset) begin
      case (state_q)
        D_IDLE: begin
          o_data_stall = d_req && (w_total != 5'd0);
          d_complete   = d_req && (w_total == 5'd0);
        end
        D_WAIT:  o_data_stall = 1'b1;
        D_DONE:  d_complete   = d_req;
        default: o_data_stall = 1'b0;
      endcase
    end
    o_ddata      = d_complete ? d_word : 32'd0;
    o_data_abort = d_complete && d_abort;
  end

  // An aborted access is never in range of a protected/missing word, so the
  // abort gate also keeps d_idx inside the array.
  always_ff @(posedge i_clk) begin
    if (!i_reset && d_complete && i_wr_en && !d_abort) begin
      for (int b = 0; b < 4; b++) begin
        if (i_ben[b]) begin
          mem[d_idx][8*b +: 8] <= i_ddata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Code port
  // ---------------------------------------------------------------------
  logic          first_q;
  logic [31:0]   last_ia_q;
  logic [3:0]    ccnt_q;
  logic          ia_changed;
  logic          i_in_range;
  logic [IW-1:0] i_idx;
  logic [31:0]   i_word;

  assign ia_changed = first_q || (i_iaddress != last_ia_q);
  assign i_in_range = (i_iaddress < SIZE_W);
  assign i_idx      = i_iaddress[IW+1:2];
  assign i_word     = i_in_range ? mem[i_idx] : 32'd0;

  // The change cycle itself is the first of CODE_WAIT miss cycles, so the
  // counter is loaded one short; with CODE_WAIT == 0 a new address hits at
  // once, except on the very first cycle out of reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      first_q   <= 1'b1;
      last_ia_q <= 32'd0;
      ccnt_q    <= CW4;
    end else if (ia_changed) begin
      first_q   <= 1'b0;
      last_ia_q <= i_iaddress;
      ccnt_q    <= (CW4 == 4'd0) ? 4'd0 : CW4 - 4'd1;
    end else if (ccnt_q != 4'd0) begin
      ccnt_q <= ccnt_q - 4'd1;
    end
  end

  always_comb begin
    o_code_hit = 1'b0;
    if (!i_reset) begin
      if (ia_changed) begin
        o_code_hit = (CW4 == 4'd0) && !first_q;
      end else begin
        o_code_hit = (ccnt_q == 4'd0);
      end
    end
    o_idata      = o_code_hit ? i_word : 32'd0;
    o_code_abort = o_code_hit &&
                   abort_check(i_iaddress, i_cpsr, SIZE_W, PROT_BASE, PROT_LIMIT);
  end

endmodule

// File: tb/tb_zap_tb_mem_ctrl.sv
// tb_zap_tb_mem_ctrl
// Directed bench for zap_tb_mem_ctrl with a cycle-level reference model of
// both ports and a random-stall instance checked against its stall bounds.
module tb_zap_tb_mem_ctrl;

  localparam int          DW    = 2;
  localparam int          CW    = 1;
  localparam logic [31:0] SIZE  = 32'd4096;
  localparam logic [31:0] PBASE = 32'h200;
  localparam logic [31:0] PLIM  = 32'h300;
  localparam logic [31:0] SVC   = 32'h0000_0013;
  localparam logic [31:0] USR   = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ia, idata, daddr, wdata, rdata_o, cpsr;
  logic        code_hit, code_abort, rd, wr, stall, dabort;
  logic [3:0]  ben;

  logic        r_rd, r_stall, r_abort, r_hit, r_cabort;
  logic [31:0] r_ddata, r_idata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  zap_tb_mem_ctrl #(
    .SIZE_IN_BYTES (4096),
    .CODE_WAIT     (CW),
    .DATA_WAIT     (DW),
    .RAND_STALL_EN (1'b0),
    .LFSR_SEED     (16'hACE1),
    .PROT_BASE     (PBASE),
    .PROT_LIMIT    (PLIM)
  ) u_dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_iaddress   (ia),
    .o_idata      (idata),
    .o_code_hit   (code_hit),
    .o_code_abort (code_abort),
    .i_daddress   (daddr),
    .i_rd_en      (rd),
    .i_wr_en      (wr),
    .i_ben        (ben),
    .i_ddata      (wdata),
    .o_ddata      (rdata_o),
    .o_data_stall (stall),
    .o_data_abort (dabort),
    .i_cpsr       (cpsr)
  );

  zap_tb_mem_ctrl #(
    .SIZE_IN_BYTES (4096),
    .CODE_WAIT     (CW),
    .DATA_WAIT     (DW),
    .RAND_STALL_EN (1'b1),
    .LFSR_SEED     (16'hACE1),
    .PROT_BASE     (32'h0),
    .PROT_LIMIT    (32'h0)
  ) u_dut_r (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_iaddress   (32'h0),
    .o_idata      (r_idata),
    .o_code_hit   (r_hit),
    .o_code_abort (r_cabort),
    .i_daddress   (32'h0),
    .i_rd_en      (r_rd),
    .i_wr_en      (1'b0),
    .i_ben        (4'h0),
    .i_ddata      (32'h0),
    .o_ddata      (r_ddata),
    .o_data_stall (r_stall),
    .o_data_abort (r_abort),
    .i_cpsr       (SVC)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no completion within cycle budget", name);
  endtask

  // Reference model: abort rule, memory image and per-port timing.
  function automatic logic abort_m(input logic [31:0] a, input logic [31:0] c);
    if (a >= SIZE) return 1'b1;
    if (c[4:0] == 5'b10000 && a >= PBASE && a < PLIM) return 1'b1;
    return 1'b0;
  endfunction

  logic [31:0] model_mem   [0:1023];
  bit          model_valid [0:1023];
  int          m_age   = 0;
  bit          m_first = 1'b1;
  logic [31:0] m_last  = 32'd0;
  int          m_run   = 0;

  logic        c_req, c_cmp, c_ab, c_hit;
  int          c_run, c_widx;
  logic [31:0] c_word;

  // A held data request stalls for DW cycles and completes on the next;
  // a fetch address hits once it has been presented for more than CW cycles.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_stall", {31'd0, stall}, 0);
      chk("rst_dabort", {31'd0, dabort}, 0);
      chk("rst_ddata", rdata_o, 0);
      chk("rst_hit", {31'd0, code_hit}, 0);
      chk("rst_cabort", {31'd0, code_abort}, 0);
      chk("rst_idata", idata, 0);
      m_age   = 0;
      m_first = 1'b1;
    end else begin
      c_run = (m_first || ia != m_last) ? 1 : m_run + 1;
      c_hit = !m_first && (c_run > CW);
      chk("m_hit", {31'd0, code_hit}, {31'd0, c_hit});
      chk("m_cabort", {31'd0, code_abort}, {31'd0, c_hit && abort_m(ia, cpsr)});
      if (!c_hit) chk("m_idata_miss", idata, 0);
      else if (ia >= SIZE) chk("m_idata_oor", idata, 0);
      else if (model_valid[ia[11:2]]) chk("m_idata", idata, model_mem[ia[11:2]]);
      m_first = 1'b0;
      m_last  = ia;
      m_run   = (c_run > 1000) ? 1000 : c_run;

      c_req = rd | wr;
      c_cmp = c_req && (m_age == DW);
      c_ab  = c_cmp && abort_m(daddr, cpsr);
      chk("m_stall", {31'd0, stall}, {31'd0, c_req && (m_age < DW)});
      chk("m_dabort", {31'd0, dabort}, {31'd0, c_ab});
      if (c_cmp) begin
        if (daddr < SIZE) begin
          c_widx = int'(daddr[11:2]);
          c_word = model_mem[c_widx];
          if (model_valid[c_widx]) chk("m_ddata", rdata_o, c_word);
          if (wr && !c_ab) begin
            for (int b = 0; b < 4; b++)
              if (ben[b]) c_word[8*b +: 8] = wdata[8*b +: 8];
            model_mem[c_widx] = c_word;
            if (ben == 4'hF) model_valid[c_widx] = 1'b1;
          end
        end else begin
          chk("m_ddata_oor", rdata_o, 0);
        end
      end
      m_age = (c_req && !c_cmp) ? m_age + 1 : 0;
    end
  end

  task automatic access(input logic [31:0] addr, input logic r, input logic w,
                        input logic [3:0] be, input logic [31:0] wd, input logic [31:0] ps,
                        output int stalls, output logic [31:0] rdv, output logic ab);
    bit done;
    @(posedge clk); #1;
    daddr = addr; rd = r; wr = w; ben = be; wdata = wd; cpsr = ps;
    stalls = 0; done = 1'b0; rdv = 32'd0; ab = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (stall) stalls++;
      else begin
        done = 1'b1;
        rdv  = rdata_o;
        ab   = dabort;
      end
    end
    if (!done) timeout("access");
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic code_step(input string name, input logic [31:0] pc, input logic [31:0] ps,
                           input logic eh, input logic ea, input logic [31:0] ed);
    @(posedge clk); #1;
    ia = pc; cpsr = ps;
    @(negedge clk);
    chk({name, "_hit"}, {31'd0, code_hit}, {31'd0, eh});
    chk({name, "_abort"}, {31'd0, code_abort}, {31'd0, ea});
    chk({name, "_idata"}, idata, ed);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s;
    logic [31:0] d;
    logic        a;
    int          mn, mx;
    bit          done;

    rst = 1'b1; ia = 32'h8; daddr = 0; rd = 0; wr = 0; ben = 0; wdata = 0; cpsr = SVC;
    r_rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", {31'd0, stall}, 0);
    chk("reset_hit", {31'd0, code_hit}, 0);
    @(posedge clk); #1 rst = 1'b0;

    access(32'h000, 0, 1, 4'hF, 32'h01020304, SVC, s, d, a);
    access(32'h004, 0, 1, 4'hF, 32'h05060708, SVC, s, d, a);
    access(32'h100, 0, 1, 4'hF, 32'hDEADBEEF, SVC, s, d, a);
    access(32'h104, 0, 1, 4'hF, 32'hAAAAAAAA, SVC, s, d, a);
    access(32'h108, 0, 1, 4'hF, 32'h77777777, SVC, s, d, a);
    access(32'h204, 0, 1, 4'hF, 32'h5A5A5A5A, SVC, s, d, a);
    chk("preload_stalls", s, 2);

    access(32'h100, 1, 0, 4'h0, 0, SVC, s, d, a);
    chk("load_stalls", s, 2);
    chk("load_data", d, 32'hDEADBEEF);
    chk("load_abort", {31'd0, a}, 0);

    access(32'h104, 0, 1, 4'b0101, 32'h11223344, SVC, s, d, a);
    chk("store_old_word", d, 32'hAAAAAAAA);
    access(32'h104, 1, 0, 4'h0, 0, SVC, s, d, a);
    chk("ben_merge", d, 32'hAA22AA44);

    access(32'h108, 1, 1, 4'hF, 32'h0A0B0C0D, SVC, s, d, a);
    chk("rdwr_old", d, 32'h77777777);
    access(32'h108, 1, 0, 4'h0, 0, SVC, s, d, a);
    chk("rdwr_new", d, 32'h0A0B0C0D);

    access(32'h204, 0, 1, 4'hF, 32'hFFFFFFFF, USR, s, d, a);
    chk("usr_store_abort", {31'd0, a}, 1);
    chk("usr_store_nowrite", u_dut.mem[129], 32'h5A5A5A5A);
    access(32'h204, 0, 1, 4'hF, 32'h0BADF00D, SVC, s, d, a);
    chk("svc_store_abort", {31'd0, a}, 0);
    chk("svc_store_write", u_dut.mem[129], 32'h0BADF00D);

    access(32'h2FC, 1, 0, 4'h0, 0, USR, s, d, a);
    chk("usr_win_top", {31'd0, a}, 1);
    access(32'h300, 1, 0, 4'h0, 0, USR, s, d, a);
    chk("usr_win_limit", {31'd0, a}, 0);
    access(32'h1FC, 1, 0, 4'h0, 0, USR, s, d, a);
    chk("usr_below_base", {31'd0, a}, 0);
    access(32'h2000, 1, 0, 4'h0, 0, SVC, s, d, a);
    chk("oor_load_abort", {31'd0, a}, 1);
    access(32'hFFC, 1, 0, 4'h0, 0, SVC, s, d, a);
    chk("last_word_abort", {31'd0, a}, 0);

    code_step("pc0a", 32'h0, SVC, 0, 0, 32'h0);
    code_step("pc0b", 32'h0, SVC, 1, 0, 32'h01020304);
    code_step("pc4a", 32'h4, SVC, 0, 0, 32'h0);
    code_step("pc4b", 32'h4, SVC, 1, 0, 32'h05060708);
    code_step("oor_a", 32'h2000, SVC, 0, 0, 32'h0);
    code_step("oor_b", 32'h2000, SVC, 1, 1, 32'h0);
    code_step("win_a", 32'h204, USR, 0, 0, 32'h0);
    code_step("win_b", 32'h204, USR, 1, 1, 32'h0BADF00D);
    code_step("win_svc", 32'h204, SVC, 1, 0, 32'h0BADF00D);

    @(posedge clk); #1;
    daddr = 32'h100; wr = 1'b1; rd = 1'b0; ben = 4'hF; wdata = 32'h12345678; cpsr = SVC;
    @(negedge clk);
    chk("rst_mid_stall1", {31'd0, stall}, 1);
    @(posedge clk); #1;
    rst = 1'b1; wr = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall_in_rst", {31'd0, stall}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall_after", {31'd0, stall}, 0);
    chk("rst_mid_mem", u_dut.mem[64], 32'hDEADBEEF);
    access(32'h100, 1, 0, 4'h0, 0, SVC, s, d, a);
    chk("rst_mid_reload_stalls", s, 2);
    chk("rst_mid_reload_data", d, 32'hDEADBEEF);

    mn = 99; mx = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1 r_rd = 1'b1;
      s = 0; done = 1'b0;
      for (int k = 0; k < 30 && !done; k++) begin
        @(negedge clk);
        if (r_stall) s++;
        else done = 1'b1;
      end
      if (!done) timeout("rand_access");
      else chk("rand_stall_in_range", {31'd0, (s >= DW) && (s <= DW + 3)}, 1);
      if (s < mn) mn = s;
      if (s > mx) mx = s;
      @(posedge clk); #1 r_rd = 1'b0;
    end
    chk("rand_stall_varies", {31'd0, mx > mn}, 1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
